// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter.
// Command bytes a host typically sends, plus the device acknowledge byte.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SHIFT,
        ST_ACK,
        ST_FINISH
    } ps2_state_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] ACK_BYTE    = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line, with a one-cycle falling-edge pulse.
// Flops reset to 1 because an idle open-collector line floats high.
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= raw;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device byte transmitter (open-collector line drive via *_oe).
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | lines released, waiting for a command byte
// INHIBIT | clock held low, then start bit asserted with clock still low
// REQ     | clock released, start bit held; device begins clocking
// SHIFT   | data, parity and stop bits driven on device falling edges
// ACK     | next falling edge samples the device acknowledge
// FINISH  | waits for both lines to float high again
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);

    ps2_state_t       state, state_d;
    logic [INH_W-1:0] timer, timer_d;
    logic [8:0]       sreg, sreg_d;
    logic [3:0]       bit_cnt, bit_cnt_d;
    logic             clk_oe, clk_oe_d;
    logic             data_oe, data_oe_d;
    logic             done, done_d;
    logic             err, err_d;

    logic clk_level, clk_fall;
    logic data_level, data_fall_unused;

    ps2_line_sync u_clk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (ps2_clk_in),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (ps2_data_in),
        .level (data_level),
        .fall  (data_fall_unused)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd, wd_d;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            timer   <= '0;
            sreg    <= '0;
            bit_cnt <= '0;
            clk_oe  <= 1'b0;
            data_oe <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wd      <= '0;
`endif
        end else begin
            state   <= state_d;
            timer   <= timer_d;
            sreg    <= sreg_d;
            bit_cnt <= bit_cnt_d;
            clk_oe  <= clk_oe_d;
            data_oe <= data_oe_d;
            done    <= done_d;
            err     <= err_d;
`ifdef PS2_TX_TIMEOUT_EN
            wd      <= wd_d;
`endif
        end
    end

    always_comb begin
        state_d   = state;
        timer_d   = timer;
        sreg_d    = sreg;
        bit_cnt_d = bit_cnt;
        clk_oe_d  = clk_oe;
        data_oe_d = data_oe;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
        wd_d      = wd;
`endif
        case (state)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    state_d   = ST_INHIBIT;
                    sreg_d    = {odd_parity(tx_data), tx_data};
                    timer_d   = INH_LOAD;
                    bit_cnt_d = '0;
                    clk_oe_d  = 1'b1;
`ifdef PS2_TX_TIMEOUT_EN
                    wd_d      = WD_LOAD;
`endif
                end
            end
            ST_INHIBIT: begin
                if (timer != '0) begin
                    timer_d = timer - INH_W'(1);
                end else if (!data_oe) begin
                    data_oe_d = 1'b1;
                end else begin
                    clk_oe_d = 1'b0;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt + 4'd1;
                    // Tenth edge releases data so the line floats high as the stop bit.
                    if (bit_cnt == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = ST_ACK;
                    end else begin
                        data_oe_d = ~sreg[0];
                        sreg_d    = {1'b0, sreg[8:1]};
                    end
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    done_d  = ~data_level;
                    err_d   = data_level;
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                if (clk_level && data_level) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        if (state inside {ST_INHIBIT, ST_REQ, ST_SHIFT, ST_ACK}) begin
            if (wd == '0) begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                done_d    = 1'b0;
                err_d     = 1'b1;
                state_d   = ST_FINISH;
            end else begin
                wd_d = wd - WD_W'(1);
            end
        end
`endif
    end

    assign tx_ready    = (state == ST_IDLE);
    assign ps2_clk_oe  = clk_oe;
    assign ps2_data_oe = data_oe;
    assign tx_done     = done;
    assign tx_err      = err;

endmodule

// File: tb/tb_ps2_tx.sv
// Scoreboard bench for ps2_tx with an open-collector PS/2 device model.
// Expected frames come from an arithmetic reference of the byte, odd parity and stop bit.
module tb_ps2_tx;

    localparam int INH  = 20;
    localparam int TO   = 500;
    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, tx_done, tx_err;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int exp_pulses = 0;

    typedef struct {
        logic [9:0] frame;
        bit         check_frame;
        bit         exp_done;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] obs_q[$];

    always #5 clk = ~clk;

    assign ps2_clk_in  = !(ps2_clk_oe || dev_clk_low);
    assign ps2_data_in = !(ps2_data_oe || dev_data_low);

    ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    // Bits as the device should see them: D0..D7, odd parity, stop = 1.
    function automatic logic [9:0] ref_frame(input logic [7:0] b);
        int v = int'(b);
        int ones = 0;
        int f;
        for (int i = 0; i < 8; i++) ones += (v >> i) & 1;
        f = v + ((ones % 2 == 0) ? 256 : 0) + 512;
        return 10'(f);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    exp_t       mon_e;
    logic [9:0] mon_o;
    always @(negedge clk) begin
        if (tx_done || tx_err) begin
            pulses++;
            check("done_err_exclusive", {31'd0, tx_done && tx_err}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("outcome_done", {31'd0, tx_done}, {31'd0, mon_e.exp_done});
                if (mon_e.check_frame) begin
                    if (obs_q.size() == 0) begin
                        check("frame_missing", 32'd1, 32'd0);
                    end else begin
                        mon_o = obs_q.pop_front();
                        check("frame", {22'd0, mon_o}, {22'd0, mon_e.frame});
                    end
                end
            end
        end
    end

    // Inhibit timing: clock alone low for INH cycles, then one cycle with start bit.
    bit prev_clk_oe = 1'b0;
    always begin
        int cnt;
        bit aborted;
        @(negedge clk);
        if (ps2_clk_oe && !prev_clk_oe && rst_n) begin
            cnt = 0;
            aborted = 1'b0;
            while (ps2_clk_oe && !ps2_data_oe && cnt < 1000) begin
                cnt++;
                @(negedge clk);
                if (!rst_n) aborted = 1'b1;
            end
            if (!aborted) check("inhibit_cycles", cnt, INH);
            cnt = 0;
            while (ps2_clk_oe && ps2_data_oe && cnt < 1000) begin
                cnt++;
                @(negedge clk);
                if (!rst_n) aborted = 1'b1;
            end
            if (!aborted) check("start_with_clk_low", cnt, 1);
        end
        prev_clk_oe = ps2_clk_oe;
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic issue(input logic [7:0] b);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic run_device(input bit ack, input int abort_after, input bit poke,
                              output bit ok, output logic [9:0] frame);
        int n = 0;
        ok = 1'b0;
        frame = '0;
        while (!(ps2_clk_in && !ps2_data_in) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n < 2000) begin
            ok = 1'b1;
            for (int e = 1; e <= 11; e++) begin
                if (e == 11) dev_data_low = ack;
                repeat (HALF) @(negedge clk);
                dev_clk_low = 1'b1;
                if (poke && e == 5) begin
                    check("ready_busy", {31'd0, tx_ready}, 32'd0);
                    tx_valid = 1'b1;
                    tx_data  = 8'h5A;
                    @(negedge clk);
                    tx_valid = 1'b0;
                    repeat (HALF - 1) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                end
                if (e <= 10) frame[e-1] = ps2_data_in;
                dev_clk_low = 1'b0;
                if (e == 10) obs_q.push_back(frame);
                if (e == 11) begin
                    repeat (HALF) @(negedge clk);
                    dev_data_low = 1'b0;
                end
                if (e == abort_after) break;
            end
        end
    endtask

    task automatic do_xfer(input logic [7:0] b, input bit ack, input bit poke);
        bit ok;
        logic [9:0] fr;
        int n;
        wait_ready(ok);
        check("ready_before", {31'd0, ok}, 32'd1);
        exp_q.push_back('{frame: ref_frame(b), check_frame: 1'b1, exp_done: ack});
        exp_pulses++;
        issue(b);
        run_device(ack, 0, poke, ok, fr);
        check("device_request", {31'd0, ok}, 32'd1);
        wait_ready(ok);
        check("ready_after", {31'd0, ok}, 32'd1);
        if (poke) begin
            n = 0;
            repeat (60) begin
                @(negedge clk);
                if (ps2_clk_oe) n++;
            end
            check("ignored_valid", n, 0);
        end else begin
            repeat (5) @(negedge clk);
        end
        check("pulse_count", pulses, exp_pulses);
        check("lines_idle", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    endtask

    initial begin
        bit ok;
        logic [9:0] fr;
        int n;
        int saved;

        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("rst_pulses", {30'd0, tx_done, tx_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, tx_ready}, 32'd1);

        do_xfer(8'hED, 1'b1, 1'b0);
        do_xfer(8'hF4, 1'b1, 1'b0);
        do_xfer(8'hA5, 1'b0, 1'b0);
        do_xfer(8'h3C, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            do_xfer(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset while the clock line is being held low.
        wait_ready(ok);
        saved = pulses;
        issue(8'h81);
        repeat (5) @(negedge clk);
        check("inhibit_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_inhibit_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_inhibit_ready", {31'd0, tx_ready}, 32'd1);

        // Reset after the fourth device clock edge of 0xFF.
        issue(8'hFF);
        run_device(1'b1, 4, 1'b0, ok, fr);
        check("abort_request", {31'd0, ok}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("rst_mid_ready", {31'd0, tx_ready}, 32'd1);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("rst_mid_ready_after", {31'd0, tx_ready}, 32'd1);
        check("rst_no_pulses", pulses, saved);
        do_xfer(8'h00, 1'b1, 1'b0);

`ifdef PS2_TX_TIMEOUT_EN
        wait_ready(ok);
        exp_q.push_back('{frame: 10'd0, check_frame: 1'b0, exp_done: 1'b0});
        exp_pulses++;
        issue(8'h96);
        n = 0;
        while (!tx_err && n < 1000) begin
            @(posedge clk);
            #1 n++;
        end
        check("timeout_latency", n, TO);
        check("timeout_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        wait_ready(ok);
        check("timeout_idle", {31'd0, ok}, 32'd1);
        repeat (3) @(negedge clk);
        check("timeout_pulses", pulses, exp_pulses);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 10000, clk cycles ps2 clock held low before request (100 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000, max clk cycles per transfer before abort (20 ms at 100 MHz).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port tx_valid  input  1  command byte request.
REQ-006 SHALL have port tx_data  input  8  command byte (e.g. 0xED set LEDs).
REQ-007 SHALL have port tx_ready  output  1  high only in IDLE; byte accepted when tx_valid && tx_ready.
REQ-008 SHALL have port ps2_clk_in  input  1  raw PS2 clock line level (asynchronous).
REQ-009 SHALL have port ps2_data_in  input  1  raw PS2 data line level (asynchronous).
REQ-010 SHALL have port ps2_clk_oe  output  1  1 = pull clock low, 0 = release (open-collector, top ties line to 0 or Z).
REQ-011 SHALL have port ps2_data_oe  output  1  1 = pull data low, 0 = release.
REQ-012 SHALL have port tx_done  output  1  one-cycle pulse, transfer acknowledged by device.
REQ-013 SHALL have port tx_err  output  1  one-cycle pulse, missing ack or timeout.

Function
REQ-014 SHALL pass ps2_clk_in/ps2_data_in through 2-flop synchronizers; a falling edge is synced clock 1 then 0 on consecutive cycles.
REQ-015 SHALL implement states IDLE, INHIBIT, REQ, SHIFT, ACK, FINISH.
REQ-016 IDLE: both oe low, tx_ready high; on accept latch tx_data, compute odd parity (~^tx_data), clear counters, go INHIBIT.
REQ-017 INHIBIT: ps2_clk_oe high for exactly INHIBIT_CYCLES cycles, then ps2_data_oe high (start bit 0) for one cycle with clock still low, then REQ.
REQ-018 REQ: ps2_clk_oe low, ps2_data_oe held high; go SHIFT.
REQ-019 SHIFT: on falling edges 1..8 drive data bits D0..D7 LSB-first (oe = ~bit); edge 9 drive parity; edge 10 release data (stop bit 1), go ACK.
REQ-020 ACK: on next falling edge sample synced data; 0 -> pulse tx_done, 1 -> pulse tx_err; go FINISH.
REQ-021 FINISH: wait until synced clock and data both high, then IDLE.
REQ-022 tx_valid while not IDLE SHALL be ignored; no queuing.
REQ-023 Glitch-free: each oe output SHALL be a flop output, at most one change per clk cycle.
REQ-024 tx_done and tx_err SHALL never assert in the same cycle.

Reset
REQ-025 During and after reset: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, tx_done=0, tx_err=0, shift register, bit and timer counters 0, synchronizers 1.
REQ-026 Reset asserted mid-transfer SHALL release both lines immediately (async) and emit no tx_done/tx_err.

Configuration
REQ-027 With macro PS2_TX_TIMEOUT_EN defined: watchdog counts from accept; reaching TIMEOUT_CYCLES in any state except IDLE/FINISH releases both lines, pulses tx_err, goes FINISH.
REQ-028 Without PS2_TX_TIMEOUT_EN: no watchdog logic; transfer waits indefinitely for device clocks; tx_err only from missing ack.

Structure
REQ-029 Package ps2_pkg SHALL hold state enum, command constants (CMD_SET_LED 8'hED, CMD_ENABLE 8'hF4, CMD_RESET 8'hFF), ack byte 8'hFA.
REQ-030 Sub-module ps2_line_sync SHALL provide the 2-flop synchronizer plus falling-edge pulse; instantiated once per line.

Verification
REQ-031 Send 0xED, device model clocks 11 edges, acks -> data bits 1,0,1,1,0,1,1,1 then parity 1, stop released, tx_done pulse once.
REQ-032 Send 0xF4 -> parity bit 0; clk_oe high exactly INHIBIT_CYCLES (use 20 in bench) before start bit.
REQ-033 Device leaves data high at edge 11 -> tx_err pulse, tx_done stays 0, both oe low.
REQ-034 With PS2_TX_TIMEOUT_EN, TIMEOUT_CYCLES=500, device never clocks -> tx_err at cycle 500 after accept, lines released, returns IDLE.
REQ-035 rst_n low after edge 4 of 0xFF -> both oe 0 same cycle, tx_ready 1 after release, no done/err; next 0x00 transfer completes with parity 1.
REQ-036 tx_valid pulsed during SHIFT -> ignored; only first byte seen on the line.
